if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- IF/ID pipeline register between the instruction-fetch unit and the decode/register-read stage of the 5-stage MIPS core.
- Captures the fetched instruction and PC+4 and adds the decode-side bookkeeping: valid bit, branch-delay-slot flag, fetch-address exception code and a stall counter.
- Applies the hazard unit's stall (hold) and the CP0/branch flush (bubble) with a fixed priority.

Parameters:
- PC_RESET, 32'h00003000, PC value reported for the bubble/reset state.
- IM_BASE, 32'h00003000, lowest legal fetch address.
- IM_LAST, 32'h00004FFC, highest legal fetch address.
- EXC_ADEL, 5'd4, ExcCode for a fetch address error.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Instr_F  in  32  instruction from the fetch stage.
- PC4_F  in  32  PC+4 from the fetch stage.
- D_En  in  1  load enable; 0 = stall, hold contents.
- Flush  in  1  insert a bubble (exception/eret redirect).
- Instr_D  out  32  instruction presented to decode.
- PC4_D  out  32  PC+4 of that instruction.
- PC8_D  out  32  PC4_D+4, the link value for jal/jalr.
- Valid_D  out  1  1 = real instruction, 0 = bubble.
- BD_D  out  1  Instr_D sits in a branch-delay slot.
- ExcCode_D  out  5  0 = none, EXC_ADEL = fetch address error.
- StallCnt  out  32  cycles spent with D_En=0 and Flush=0 since reset.

Behaviour:
- Reset values: Instr_D=0, PC4_D=PC_RESET+4, Valid_D=0, BD_D=0, ExcCode_D=0, StallCnt=0.
- Priority at each rising Clk edge:
  - Reset
  - Flush: load bubble regardless of D_En.
  - D_En=0: hold every register; StallCnt+1.
  - Load.
- Bubble: Instr_D=0 (sll $0,$0,0), Valid_D=0, BD_D=0, ExcCode_D=0, PC4_D=PC4_F. The PC is kept for EPC. StallCnt is unchanged.
- Load:
  - Fetch PC = PC4_F-4.
  - If PC[1:0]!=0 or PC<IM_BASE or PC>IM_LAST: ExcCode_D=EXC_ADEL and Instr_D=0 (never pass a garbage instruction). Otherwise ExcCode_D=0 and Instr_D=Instr_F.
  - Valid_D=1. PC4_D=PC4_F.
  - BD_D = Valid_D & is_branch(Instr_D). This uses the old register values: the instruction now leaving decode.
- is_branch(i) is true for:
  - op 000100 beq, 000101 bne, 000110 blez, 000111 bgtz, 000001 bltz/bgez, 000010 j, 000011 jal.
  - op 000000 with funct 001000 jr or 001001 jalr.
- BD_D across stalls: held with the rest. A stalled delay slot keeps BD_D=1 until it advances.
- Flush arriving while the delay slot is being loaded: Flush wins, BD_D=0.
- PC8_D: combinational PC4_D+4, wraps modulo 2^32.
- StallCnt: wraps 32'hFFFFFFFF→0 with no saturation.
- Latency: exactly one cycle from Instr_F to Instr_D. No combinational path from any input to any output.

Decomposition:
- Shared package mips_defs holds:
  - opcode/funct localparams (OP_BEQ, OP_REGIMM, OP_J, OP_JAL, FN_JR, FN_JALR ...), NOP=32'h0.
  - ExcCode constants (EXC_NONE, EXC_ADEL), reused by CP0 and later stages.
- One sub-module: branch_classify, combinational is_branch(Instr) → 1 bit, shared later with the decode-stage NPC logic.
- Register bank and address check stay in if_id_stage.

Test Plan:
- Reset: hold Reset 2 cycles with D_En=1 → Instr_D=0, Valid_D=0, PC4_D=32'h3004, PC8_D=32'h3008, StallCnt=0.
- Normal load: Instr_F=32'h8C220004, PC4_F=32'h3008, D_En=1 → next cycle Instr_D=32'h8C220004, PC4_D=32'h3008, PC8_D=32'h300C, Valid_D=1, ExcCode_D=0, BD_D=0.
- Stall: after a load, D_En=0 for 3 cycles while Instr_F changes → Instr_D/PC4_D unchanged, StallCnt=3. Then D_En=1 → new instruction loaded.
- Delay slot:
  - Load beq 32'h10220003 then 32'h00000000 → second load has BD_D=1.
  - Stall 2 cycles there → BD_D stays 1.
  - Flush while the slot loads → Valid_D=0, BD_D=0.
- Address error:
  - PC4_F=32'h3006 → ExcCode_D=4, Instr_D=0, Valid_D=1.
  - PC4_F=32'h5004 → ExcCode_D=4.
  - PC4_F=32'h5000 → ExcCode_D=0.
- Priority: Flush=1 with D_En=0 → bubble loaded, StallCnt not incremented. Reset=1 with Flush=1 → reset values.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS encoding constants and the IF/ID register layout.
package mips_defs;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    // SPECIAL function codes (instr[5:0])
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    // sll $0,$0,0 -- the canonical bubble instruction
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Exception codes shared with CP0 and later stages
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        bd;
        logic [4:0]  exc;
    } if_id_t;

endpackage

// File: rtl/if_id_stage_branch_classify.sv
// Flags instructions whose successor executes in a branch-delay slot.
module branch_classify
    import mips_defs::*;
(
    input  logic [31:0] instr_i,
    output logic        is_branch_o
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_fields;

    assign op    = instr_i[31:26];
    assign funct = instr_i[5:0];
    // Register/immediate fields play no part in the classification.
    assign unused_fields = ^instr_i[25:6];

    // Decode opcode (and funct for SPECIAL) into a control-transfer flag
    always_comb begin
        is_branch_o = 1'b0;
        case (op)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
            OP_REGIMM, OP_J, OP_JAL: is_branch_o = 1'b1;
            OP_SPECIAL:              is_branch_o = (funct == FN_JR) || (funct == FN_JALR);
            default:                 is_branch_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: captures the fetched instruction and PC+4,
// adds valid / delay-slot / fetch-exception bookkeeping and counts stalls.
// Priority per edge: Reset > Flush (bubble) > stall (hold) > load.
module if_id_stage
    import mips_defs::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_LAST  = 32'h0000_4FFC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr_F,
    input  logic [31:0] PC4_F,
    input  logic        D_En,
    input  logic        Flush,
    output logic [31:0] Instr_D,
    output logic [31:0] PC4_D,
    output logic [31:0] PC8_D,
    output logic        Valid_D,
    output logic        BD_D,
    output logic [4:0]  ExcCode_D,
    output logic [31:0] StallCnt
);

    if_id_t      stage_q, stage_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fetch_pc;
    logic        addr_err;
    logic        cur_is_branch;

    // The delay-slot flag looks at the instruction currently in decode,
    // i.e. the one being replaced, not the one arriving.
    branch_classify u_branch_classify (
        .instr_i     (stage_q.instr),
        .is_branch_o (cur_is_branch)
    );

    assign fetch_pc = PC4_F - 32'd4;
    assign addr_err = (fetch_pc[1:0] != 2'b00) || (fetch_pc < IM_BASE) || (fetch_pc > IM_LAST);

    // Next-state selection: bubble, hold-and-count, or load
    always_comb begin
        stage_d     = stage_q;
        stall_cnt_d = stall_cnt_q;
        if (Flush) begin
            // PC is kept so CP0 can still form EPC from the bubble.
            stage_d.instr = NOP;
            stage_d.pc4   = PC4_F;
            stage_d.valid = 1'b0;
            stage_d.bd    = 1'b0;
            stage_d.exc   = EXC_NONE;
        end else if (!D_En) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            // A bad fetch address never lets its (garbage) word through.
            stage_d.instr = addr_err ? NOP : Instr_F;
            stage_d.pc4   = PC4_F;
            stage_d.valid = 1'b1;
            stage_d.bd    = stage_q.valid & cur_is_branch;
            stage_d.exc   = addr_err ? EXC_ADEL : EXC_NONE;
        end
    end

    // Register bank with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stage_q.instr <= NOP;
            stage_q.pc4   <= PC_RESET + 32'd4;
            stage_q.valid <= 1'b0;
            stage_q.bd    <= 1'b0;
            stage_q.exc   <= EXC_NONE;
            stall_cnt_q   <= 32'd0;
        end else begin
            stage_q       <= stage_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign Instr_D   = stage_q.instr;
    assign PC4_D     = stage_q.pc4;
    assign PC8_D     = stage_q.pc4 + 32'd4;
    assign Valid_D   = stage_q.valid;
    assign BD_D      = stage_q.bd;
    assign ExcCode_D = stage_q.exc;
    assign StallCnt  = stall_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed table-driven bench for the IF/ID pipeline register.
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instr_f;
    logic [31:0] pc4_f;
    logic        d_en;
    logic        flush;
    logic [31:0] instr_d;
    logic [31:0] pc4_d;
    logic [31:0] pc8_d;
    logic        valid_d;
    logic        bd_d;
    logic [4:0]  exc_d;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    if_id_stage dut (
        .Clk       (clk),
        .Reset     (rst),
        .Instr_F   (instr_f),
        .PC4_F     (pc4_f),
        .D_En      (d_en),
        .Flush     (flush),
        .Instr_D   (instr_d),
        .PC4_D     (pc4_d),
        .PC8_D     (pc8_d),
        .Valid_D   (valid_d),
        .BD_D      (bd_d),
        .ExcCode_D (exc_d),
        .StallCnt  (stall_cnt)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        en;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic        e_bd;
        logic [4:0]  e_exc;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NV = 29;
    vec_t vec [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                             input logic ev, input logic eb, input logic [4:0] ee,
                             input logic [31:0] ec);
        check({tag, ".Instr_D"},   instr_d, ei);
        check({tag, ".PC4_D"},     pc4_d, ep);
        check({tag, ".PC8_D"},     pc8_d, ep + 32'd4);
        check({tag, ".Valid_D"},   {31'd0, valid_d}, {31'd0, ev});
        check({tag, ".BD_D"},      {31'd0, bd_d}, {31'd0, eb});
        check({tag, ".ExcCode_D"}, {27'd0, exc_d}, {27'd0, ee});
        check({tag, ".StallCnt"},  stall_cnt, ec);
    endtask

    task automatic drive(input logic r, input logic f, input logic e,
                         input logic [31:0] i, input logic [31:0] p);
        @(negedge clk);
        rst = r; flush = f; d_en = e; instr_f = i; pc4_f = p;
    endtask

    localparam logic [31:0] LW  = 32'h8C22_0004;
    localparam logic [31:0] BEQ = 32'h1022_0003;
    localparam logic [31:0] ADD = 32'h0043_0820;
    localparam logic [31:0] J   = 32'h0800_0C00;
    localparam logic [31:0] JR  = 32'h03E0_0008;

    initial begin
        rst = 1'b1; flush = 1'b0; d_en = 1'b1; instr_f = '0; pc4_f = 32'h3008;

        //          rst   fl    en    instr_f        pc4_f          e_instr        e_pc4          v     bd    exc   cnt
        vec[0]  = '{1'b1, 1'b0, 1'b1, LW,            32'h3008,      32'h0,         32'h3004,      1'b0, 1'b0, 5'd0, 32'd0};
        vec[1]  = '{1'b1, 1'b0, 1'b1, LW,            32'h3008,      32'h0,         32'h3004,      1'b0, 1'b0, 5'd0, 32'd0};
        vec[2]  = '{1'b0, 1'b0, 1'b1, LW,            32'h3008,      LW,            32'h3008,      1'b1, 1'b0, 5'd0, 32'd0};
        vec[3]  = '{1'b0, 1'b0, 1'b0, 32'hAAAA_AAAA, 32'h300C,      LW,            32'h3008,      1'b1, 1'b0, 5'd0, 32'd1};
        vec[4]  = '{1'b0, 1'b0, 1'b0, 32'hBBBB_BBBB, 32'h3010,      LW,            32'h3008,      1'b1, 1'b0, 5'd0, 32'd2};
        vec[5]  = '{1'b0, 1'b0, 1'b0, 32'hCCCC_CCCC, 32'h3014,      LW,            32'h3008,      1'b1, 1'b0, 5'd0, 32'd3};
        vec[6]  = '{1'b0, 1'b0, 1'b1, ADD,           32'h300C,      ADD,           32'h300C,      1'b1, 1'b0, 5'd0, 32'd3};
        // beq followed by its delay slot, which then stalls twice
        vec[7]  = '{1'b0, 1'b0, 1'b1, BEQ,           32'h3010,      BEQ,           32'h3010,      1'b1, 1'b0, 5'd0, 32'd3};
        vec[8]  = '{1'b0, 1'b0, 1'b1, 32'h0,         32'h3014,      32'h0,         32'h3014,      1'b1, 1'b1, 5'd0, 32'd3};
        vec[9]  = '{1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h3018,      32'h0,         32'h3014,      1'b1, 1'b1, 5'd0, 32'd4};
        vec[10] = '{1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h3018,      32'h0,         32'h3014,      1'b1, 1'b1, 5'd0, 32'd5};
        vec[11] = '{1'b0, 1'b0, 1'b1, 32'h2401_0001, 32'h3018,      32'h2401_0001, 32'h3018,      1'b1, 1'b0, 5'd0, 32'd5};
        // beq, then Flush while its delay slot loads
        vec[12] = '{1'b0, 1'b0, 1'b1, BEQ,           32'h301C,      BEQ,           32'h301C,      1'b1, 1'b0, 5'd0, 32'd5};
        vec[13] = '{1'b0, 1'b1, 1'b1, 32'h0,         32'h3020,      32'h0,         32'h3020,      1'b0, 1'b0, 5'd0, 32'd5};
        // j after a bubble (not a slot), jr makes the next one a slot
        vec[14] = '{1'b0, 1'b0, 1'b1, J,             32'h3024,      J,             32'h3024,      1'b1, 1'b0, 5'd0, 32'd5};
        vec[15] = '{1'b0, 1'b0, 1'b1, JR,            32'h3028,      JR,            32'h3028,      1'b1, 1'b1, 5'd0, 32'd5};
        vec[16] = '{1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h302C,      32'h0000_1234, 32'h302C,      1'b1, 1'b1, 5'd0, 32'd5};
        vec[17] = '{1'b0, 1'b0, 1'b1, 32'h0,         32'h3030,      32'h0,         32'h3030,      1'b1, 1'b0, 5'd0, 32'd5};
        // fetch address checks
        vec[18] = '{1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h3006,      32'h0,         32'h3006,      1'b1, 1'b0, 5'd4, 32'd5};
        vec[19] = '{1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h5004,      32'h0,         32'h5004,      1'b1, 1'b0, 5'd4, 32'd5};
        vec[20] = '{1'b0, 1'b0, 1'b1, 32'h1111_1111, 32'h5000,      32'h1111_1111, 32'h5000,      1'b1, 1'b0, 5'd0, 32'd5};
        vec[21] = '{1'b0, 1'b0, 1'b1, 32'h0,         32'h3004,      32'h0,         32'h3004,      1'b1, 1'b1, 5'd0, 32'd5};
        vec[22] = '{1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h3000,      32'h0,         32'h3000,      1'b1, 1'b0, 5'd4, 32'd5};
        vec[23] = '{1'b0, 1'b0, 1'b1, 32'h0000_0005, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, 1'b1, 1'b0, 5'd4, 32'd5};
        // priority: Flush over stall, Reset over Flush
        vec[24] = '{1'b0, 1'b1, 1'b0, 32'h7777_7777, 32'h3040,      32'h0,         32'h3040,      1'b0, 1'b0, 5'd0, 32'd5};
        vec[25] = '{1'b0, 1'b0, 1'b0, 32'h7777_7777, 32'h3044,      32'h0,         32'h3040,      1'b0, 1'b0, 5'd0, 32'd6};
        vec[26] = '{1'b1, 1'b1, 1'b1, 32'h7777_7777, 32'h3048,      32'h0,         32'h3004,      1'b0, 1'b0, 5'd0, 32'd0};
        // a branch squashed by an address error does not create a slot
        vec[27] = '{1'b0, 1'b0, 1'b1, BEQ,           32'h3006,      32'h0,         32'h3006,      1'b1, 1'b0, 5'd4, 32'd0};
        vec[28] = '{1'b0, 1'b0, 1'b1, ADD,           32'h3008,      ADD,           32'h3008,      1'b1, 1'b0, 5'd0, 32'd0};

        for (int i = 0; i < NV; i++) begin
            drive(vec[i].rst, vec[i].flush, vec[i].en, vec[i].instr, vec[i].pc4);
            @(posedge clk);
            #1;
            check_all($sformatf("v%0d", i), vec[i].e_instr, vec[i].e_pc4, vec[i].e_valid,
                      vec[i].e_bd, vec[i].e_exc, vec[i].e_cnt);
        end

        // Outputs must not follow inputs between edges.
        @(negedge clk);
        rst = 1'b1; flush = 1'b1; d_en = 1'b0; instr_f = 32'hFFFF_FFFF; pc4_f = 32'h0;
        #2;
        check_all("comb", ADD, 32'h3008, 1'b1, 1'b0, 5'd0, 32'd0);

        // Long stall run after reset: counter tracks every held cycle.
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h3008);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b0, $urandom_range(0, 1000), 32'h3010);
        end
        @(posedge clk);
        #1;
        check_all("stall20", 32'h0, 32'h3004, 1'b0, 1'b0, 5'd0, 32'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
